mem_port_arbiter: RTL

Parametrised N-channel arbiter merging several request ports (fetch, memory, future DMA/debug) onto the single `mem_*` port of the core's memory bus. It generalises the fixed split IMem/DMem interface of the core top level into `NUM_CH` channels with selectable round-robin or fixed priority and a per-transaction timeout that reports an error instead of hanging the pipeline. It sits between the pipeline stages and the external memory, one transaction outstanding at a time.

---
 rtl/mem_port_arbiter_if.sv | 32 +++
 rtl/mem_port_arbiter.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Request/response bundle between NUM_CH requesters, the arbiter and the shared memory port.
// The arbiter connects through the slave modport; the requester/memory side uses master.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int NUM_CH = 2
);
  logic [NUM_CH*ADDR_W-1:0] ch_addr;
  logic [NUM_CH-1:0]        ch_rd_enable;
  logic [NUM_CH-1:0]        ch_wr_enable;
  logic [NUM_CH*DATA_W-1:0] ch_wr_data;
  logic [DATA_W-1:0]        ch_rd_data;
  logic [NUM_CH-1:0]        ch_ready;
  logic [NUM_CH-1:0]        ch_err;

  logic [ADDR_W-1:0]        mem_addr;
  logic [DATA_W-1:0]        mem_wr_data;
  logic                     mem_rd_enable;
  logic                     mem_wr_enable;
  logic [DATA_W-1:0]        mem_rd_data;
  logic                     mem_ready;

  modport slave (
    input  ch_addr, ch_rd_enable, ch_wr_enable, ch_wr_data, mem_rd_data, mem_ready,
    output ch_rd_data, ch_ready, ch_err, mem_addr, mem_wr_data, mem_rd_enable, mem_wr_enable
  );

  modport master (
    output ch_addr, ch_rd_enable, ch_wr_enable, ch_wr_data, mem_rd_data, mem_ready,
    input  ch_rd_data, ch_ready, ch_err, mem_addr, mem_wr_data, mem_rd_enable, mem_wr_enable
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Merges NUM_CH request channels onto one memory port, one transaction outstanding at a time.
// Round-robin or fixed-priority grant; a stalled memory is reported through a ch_err pulse.
module mem_port_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int NUM_CH    = 2,
  parameter int PRIO_MODE = 0,
  parameter int TIMEOUT   = 255
) (
  input  logic              clk,
  input  logic              reset,
  mem_port_arbiter_if.slave bus
);
  localparam int GW    = $clog2(NUM_CH);
  localparam int CNT_W = (TIMEOUT > 255) ? 16 : 8;
  localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state_q;
  logic [GW-1:0]     grant_q;
  logic [GW-1:0]     rr_ptr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wr_data_q;
  logic              mem_rd_en_q;
  logic              mem_wr_en_q;
  logic [NUM_CH-1:0] ch_ready_q;
  logic [NUM_CH-1:0] ch_err_q;
  logic [DATA_W-1:0] ch_rd_data_q;

  logic [NUM_CH-1:0] req;
  logic              found_d;
  logic [GW-1:0]     start_d;
  logic [GW-1:0]     grant_d;
  logic [GW-1:0]     rr_next_d;
  logic [ADDR_W-1:0] sel_addr_d;
  logic [DATA_W-1:0] sel_wdata_d;
  logic              sel_wr_d;
  logic [NUM_CH-1:0] grant_oh;

  assign req = bus.ch_rd_enable | bus.ch_wr_enable;

  // Two ascending scans: channels at/after the start point first, then the wrap-around.
  always_comb begin
    found_d     = 1'b0;
    grant_d     = '0;
    start_d     = (PRIO_MODE != 0) ? '0 : rr_ptr_q;
    sel_addr_d  = '0;
    sel_wdata_d = '0;
    sel_wr_d    = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!found_d && req[k] && (GW'(k) >= start_d)) begin
        found_d = 1'b1;
        grant_d = GW'(k);
      end
    end
    for (int k = 0; k < NUM_CH; k++) begin
      if (!found_d && req[k]) begin
        found_d = 1'b1;
        grant_d = GW'(k);
      end
    end
    for (int k = 0; k < NUM_CH; k++) begin
      if (grant_d == GW'(k)) begin
        sel_addr_d  = bus.ch_addr[k*ADDR_W +: ADDR_W];
        sel_wdata_d = bus.ch_wr_data[k*DATA_W +: DATA_W];
        sel_wr_d    = bus.ch_wr_enable[k];
      end
    end
    rr_next_d = (grant_d == GW'(NUM_CH - 1)) ? '0 : grant_d + GW'(1);
  end

  always_comb begin
    grant_oh = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      grant_oh[k] = (grant_q == GW'(k));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      rr_ptr_q      <= '0;
      cnt_q         <= '0;
      mem_addr_q    <= '0;
      mem_wr_data_q <= '0;
      mem_rd_en_q   <= 1'b0;
      mem_wr_en_q   <= 1'b0;
      ch_ready_q    <= '0;
      ch_err_q      <= '0;
      ch_rd_data_q  <= '0;
    end else begin
      ch_ready_q <= '0;
      ch_err_q   <= '0;
      unique case (state_q)
        IDLE: begin
          if (found_d) begin
            state_q       <= BUSY;
            grant_q       <= grant_d;
            cnt_q         <= '0;
            mem_addr_q    <= sel_addr_d;
            mem_wr_data_q <= sel_wdata_d;
            mem_wr_en_q   <= sel_wr_d;
            mem_rd_en_q   <= !sel_wr_d;
            if (PRIO_MODE == 0) begin
              rr_ptr_q <= rr_next_d;
            end
          end
        end
        BUSY: begin
          // A response arriving on the limit cycle still counts as success.
          if (bus.mem_ready) begin
            state_q      <= DONE;
            ch_ready_q   <= grant_oh;
            ch_rd_data_q <= mem_wr_en_q ? '0 : bus.mem_rd_data;
            mem_rd_en_q  <= 1'b0;
            mem_wr_en_q  <= 1'b0;
          end else if ((TIMEOUT != 0) && (cnt_q == TO_CNT)) begin
            state_q      <= DONE;
            ch_err_q     <= grant_oh;
            ch_rd_data_q <= '0;
            mem_rd_en_q  <= 1'b0;
            mem_wr_en_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.mem_addr      = mem_addr_q;
  assign bus.mem_wr_data   = mem_wr_data_q;
  assign bus.mem_rd_enable = mem_rd_en_q;
  assign bus.mem_wr_enable = mem_wr_en_q;
  assign bus.ch_ready      = ch_ready_q;
  assign bus.ch_err        = ch_err_q;
  assign bus.ch_rd_data    = ch_rd_data_q;
endmodule
